// File: rtl/mux_nx1_rr.sv
// -----------------------------------------------------------------------------
// mux_nx1_rr
//
// Registered N-to-1 multiplexer with a valid/ready style output stage. Each of
// the N input channels offers a WIDTH-bit word together with a valid bit. One
// channel per cycle may be granted. A granted channel sees its popEntradas bit
// go high in the same cycle, and its word shows up on Salida on the next edge.
//
// Two arbitration modes, chosen at elaboration time:
//   MODE 0 : selector mode. The channel addressed by 'selector' is granted if
//            it is valid.
//   MODE 1 : round-robin mode. The search starts one past the last granted
//            channel and wraps around.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : synchronous, active-low reset
//   Entradas       : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   validEntradas  : per-channel valid
//   selector       : channel index (MODE 0 only)
//   readySalida    : downstream accepts the current output word
//   Salida         : registered output word
//   validSalida    : registered, Salida holds a word not yet accepted
//   canalSalida    : registered index of the channel that produced Salida
//   popEntradas    : combinational one-hot, channel consumed this cycle
// -----------------------------------------------------------------------------
module mux_nx1_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N*WIDTH-1:0]     Entradas,
  input  logic [N-1:0]           validEntradas,
  input  logic [$clog2(N)-1:0]   selector,
  input  logic                   readySalida,
  output logic [WIDTH-1:0]       Salida,
  output logic                   validSalida,
  output logic [$clog2(N)-1:0]   canalSalida,
  output logic [N-1:0]           popEntradas
);

  localparam int SELW = $clog2(N);

  logic [WIDTH-1:0] salida_q, salida_d;
  logic             valid_q,  valid_d;
  logic [SELW-1:0]  canal_q,  canal_d;
  logic [SELW-1:0]  ptr_q,    ptr_d;

  logic             load;
  logic             selGrant;
  logic             rrGrant;
  logic [SELW-1:0]  rrIdx;
  logic [SELW-1:0]  candIdx;
  logic             grant;
  logic [SELW-1:0]  grantIdx;
  logic [WIDTH-1:0] grantData;

  // Arbitration. The output register can take a new word when it is empty or
  // its current word is being accepted this cycle. The round-robin search
  // walks from ptr+N down to ptr+1 so the last hit wins. That makes the
  // closest valid channel after ptr the winner without needing an early exit.
  // Index arithmetic is SELW bits wide, so the wrap-around comes for free
  // because N is a power of two.
  always_comb begin
    load     = !valid_q || readySalida;
    selGrant = validEntradas[selector];
    rrGrant  = 1'b0;
    rrIdx    = '0;
    candIdx  = '0;
    for (int k = N; k >= 1; k--) begin
      candIdx = ptr_q + SELW'(k);
      if (validEntradas[candIdx]) begin
        rrGrant = 1'b1;
        rrIdx   = candIdx;
      end
    end
    grant     = load && ((MODE == 0) ? selGrant : rrGrant);
    grantIdx  = (MODE == 0) ? selector : rrIdx;
    grantData = Entradas[grantIdx*WIDTH +: WIDTH];
  end

  // The pop is suppressed while reset is low. A word the block is not going
  // to capture must never be consumed from the channel.
  always_comb begin
    popEntradas = '0;
    if (reset && grant) begin
      popEntradas = N'(1) << grantIdx;
    end
  end

  // Next-state logic for the output stage and the round-robin pointer. On a
  // load with no grant, only the valid flag drops. The stale data and index
  // are left in place.
  always_comb begin
    salida_d = salida_q;
    valid_d  = valid_q;
    canal_d  = canal_q;
    ptr_d    = ptr_q;
    if (load) begin
      if (grant) begin
        salida_d = grantData;
        valid_d  = 1'b1;
        canal_d  = grantIdx;
        ptr_d    = grantIdx;
      end else begin
        valid_d  = 1'b0;
      end
    end
  end

  // State registers. The pointer resets to N-1 so that the first round-robin
  // grant lands on channel 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      salida_q <= '0;
      valid_q  <= 1'b0;
      canal_q  <= '0;
      ptr_q    <= SELW'(N - 1);
    end else begin
      salida_q <= salida_d;
      valid_q  <= valid_d;
      canal_q  <= canal_d;
      ptr_q    <= ptr_d;
    end
  end

  assign Salida      = salida_q;
  assign validSalida = valid_q;
  assign canalSalida = canal_q;

endmodule

// File: doc/mux_nx1_rr.md
MUX_NX1_RR -- requirements
Module: mux_nx1_rr

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel (1..32).
REQ-002 Parameter N, default 4, channel count (power of two, 2..16); SELW = log2(N).
REQ-003 Parameter MODE, default 0: 0 = selector mode, 1 = round-robin mode.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-006 Entradas  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-007 validEntradas  input  N  bit i high = channel i offers a word this cycle.
REQ-008 selector  input  SELW  channel index used in MODE 0; ignored in MODE 1.
REQ-009 readySalida  input  1  downstream accepts the current output word this cycle.
REQ-010 Salida  output  WIDTH  registered output word.
REQ-011 validSalida  output  1  registered; Salida holds a word not yet accepted.
REQ-012 canalSalida  output  SELW  registered index of the channel that produced Salida.
REQ-013 popEntradas  output  N  combinational one-hot; bit i high = channel i's word is consumed this cycle.

Function
REQ-014 Load condition: load = !validSalida || readySalida, evaluated every cycle.
REQ-015 MODE 0 grant: when load=1 and validEntradas[selector]=1, the block shall grant channel selector.
REQ-016 MODE 1 grant: when load=1, the block shall grant the first channel with valid=1, searching from (ptr+1) mod N upward with wrap-around.
REQ-017 Exactly one popEntradas bit shall be high in a cycle with a grant; all bits shall be low otherwise, and all bits shall be low while reset is low.
REQ-018 On the edge after a grant, Salida, canalSalida and validSalida shall take the granted channel's data, the granted index and 1 respectively; latency is one cycle from pop to validSalida.
REQ-019 If load=1 and no grant occurs, validSalida shall go to 0 on the next edge, and Salida and canalSalida shall hold their values.
REQ-020 If load=0 (validSalida=1, readySalida=0), Salida, validSalida and canalSalida shall hold, popEntradas shall be 0, and ptr shall hold.
REQ-021 ptr (SELW-bit, MODE 1 only) shall update to the granted index on every grant and hold otherwise.
REQ-022 Simultaneous accept and grant (validSalida=1, readySalida=1, grant) shall replace the word in the same edge with no bubble, sustaining one word per cycle.
REQ-023 In MODE 1 with all channels valid continuously and readySalida=1, the grant sequence shall be 0,1,...,N-1,0,...; each channel is granted at most once in any N consecutive grants while others are pending.
REQ-024 Changing selector while load=0 shall have no effect until load returns to 1.

Reset
REQ-025 While reset=0 at a rising edge: Salida=0, validSalida=0, canalSalida=0, ptr=N-1 (first MODE 1 grant goes to channel 0).
REQ-026 Reset asserted mid-transfer shall discard the held word without a pop; the first grant after release shall follow REQ-015/016 from the reset state.

Verification
REQ-027 MODE 0, N=4, WIDTH=8: selector=2, Entradas ch2=0xA5, valid=0100, ready=1 -> pop=0100 in cycle t; Salida=0xA5, canalSalida=2, validSalida=1 at t+1.
REQ-028 MODE 1: valid=1111, data ch i = 0x10+i, ready=1 for 8 cycles -> Salida sequence 0x10,0x11,0x12,0x13,0x10,0x11,0x12,0x13 with no gaps.
REQ-029 Backpressure: output holds 0x11, ready=0 for 3 cycles with valid=1111 -> Salida=0x11 held, pop=0000, ptr unchanged; after ready=1, next word is 0x12.
REQ-030 Sparse round-robin: ptr=1, valid=1001 -> grant ch3; next cycle valid=1001 -> grant ch0 (wrap-around).
REQ-031 Empty: validSalida=1, ready=1, valid=0000 -> validSalida=0 next edge, Salida unchanged, pop=0000.
REQ-032 Reset mid-operation: reset=0 during backpressure hold -> next edge Salida=0, validSalida=0, canalSalida=0; after release with valid=1111 in MODE 1, first grant is ch0.
